// File: rtl/fir_pkg.sv
// Shared FIR widths and the rounding helper used by the tap chain and the output quantizer.
package fir_pkg;

    localparam int unsigned FirIw    = 16;
    localparam int unsigned FirTw    = 16;
    localparam int unsigned FirOw    = FirIw + FirTw + 8;
    localparam int unsigned FirShift = 15;
    localparam int unsigned FirDepth = 4;

    // Half an output LSB at accumulator scale; added before the arithmetic right shift.
    function automatic logic [63:0] round_k(input int unsigned shift);
        return 64'd1 << (shift - 1);
    endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// Synchronous show-ahead FIFO with wrap-bit pointers, level output and a pop-assisted full write.
module fir_out_fifo #(
    parameter int unsigned Width = 16,
    parameter int unsigned Depth = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   level_o
);
    localparam int unsigned AW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    assign do_pop  = pop_i && !empty_o;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/fir_out_quantizer.sv
// FIR output stage: captures the last accumulator, rounds half-up, rescales, buffers results.
// Define FIR_OUT_SAT_EN to clamp to IW bits and expose the sticky o_sat flag.
module fir_out_quantizer
    import fir_pkg::*;
#(
    parameter int unsigned IW    = FirIw,
    parameter int unsigned OW    = FirOw,
    parameter int unsigned SHIFT = FirShift,
    parameter int unsigned DEPTH = FirDepth
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_ce,
    input  logic [OW-1:0]            i_acc,
    output logic [IW-1:0]            o_data,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overflow,
    input  logic                     i_clr_ovf
`ifdef FIR_OUT_SAT_EN
    ,
    output logic                     o_sat
`endif
);
    localparam logic [OW:0] RoundK = (OW + 1)'(round_k(SHIFT));

    logic               ce_q;
    logic               s1_v_q;
    logic signed [OW:0] s1_q, s1_d;
    logic signed [OW:0] q;
    logic [IW-1:0]      q_res;
    logic               fifo_full, fifo_empty;
    logic               pop, drop;
    logic               ovf_q, ovf_d;

    // One guard bit above the sign-extended accumulator keeps the rounding add exact.
    assign s1_d = {i_acc[OW-1], i_acc} + RoundK;
    assign q    = s1_q >>> SHIFT;

`ifdef FIR_OUT_SAT_EN
    logic [OW-IW+1:0] q_hi;
    logic             q_clamped;
    logic             sat_q, sat_d;

    assign q_hi      = q[OW:IW-1];
    assign q_clamped = !((&q_hi) || !(|q_hi));
    assign q_res     = q_clamped ? {q[OW], {(IW-1){!q[OW]}}} : q[IW-1:0];

    always_comb begin
        sat_d = sat_q;
        if (i_clr_ovf) sat_d = 1'b0;
        if (s1_v_q && !drop && q_clamped) sat_d = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) sat_q <= 1'b0;
        else         sat_q <= sat_d;
    end

    assign o_sat = sat_q;
`else
    logic unused_q_hi;

    assign q_res       = q[IW-1:0];
    assign unused_q_hi = ^q[OW:IW];
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ce_q   <= 1'b0;
            s1_v_q <= 1'b0;
            s1_q   <= '0;
        end else begin
            ce_q   <= i_ce;
            s1_v_q <= ce_q;
            if (ce_q) s1_q <= s1_d;
        end
    end

    assign pop  = o_valid && i_ready;
    assign drop = s1_v_q && fifo_full && !pop;

    // A drop in the same cycle as a clear leaves the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (i_clr_ovf) ovf_d = 1'b0;
        if (drop)      ovf_d = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) ovf_q <= 1'b0;
        else         ovf_q <= ovf_d;
    end

    assign o_overflow = ovf_q;
    assign o_valid    = !fifo_empty;

    fir_out_fifo #(
        .Width (IW),
        .Depth (DEPTH)
    ) u_fifo (
        .clk_i   (i_clk),
        .rst_i   (i_reset),
        .push_i  (s1_v_q),
        .wdata_i (q_res),
        .pop_i   (pop),
        .rdata_o (o_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (o_level)
    );

endmodule

// File: tb/tb_fir_out_quantizer.sv
// Self-checking bench for fir_out_quantizer: directed vectors, corner sequences, random traffic.
`timescale 1ns/1ps
module tb_fir_out_quantizer;
    localparam int unsigned IW    = 16;
    localparam int unsigned OW    = 40;
    localparam int unsigned SHIFT = 15;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce;
    logic          ready;
    logic          clr;
    logic [OW-1:0] acc;
    logic [IW-1:0] data;
    logic          valid;
    logic [LW-1:0] level;
    logic          ovf;
`ifdef FIR_OUT_SAT_EN
    logic          sat;
`endif

    always #5 clk = ~clk;

    fir_out_quantizer #(
        .IW    (IW),
        .OW    (OW),
        .SHIFT (SHIFT),
        .DEPTH (DEPTH)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_ce       (ce),
        .i_acc      (acc),
        .o_data     (data),
        .o_valid    (valid),
        .i_ready    (ready),
        .o_level    (level),
        .o_overflow (ovf),
        .i_clr_ovf  (clr)
`ifdef FIR_OUT_SAT_EN
        ,
        .o_sat      (sat)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a queue of delivered samples plus the two-cycle capture pipeline.
    logic [IW-1:0] mq[$];
    bit            m_ce_q, m_s1_v, m_s1_sat, m_ovf, m_sat;
    logic [IW-1:0] m_s1_val;

    typedef struct {
        logic [OW-1:0] acc;
        logic [IW-1:0] exp_wrap;
        logic [IW-1:0] exp_sat;
        bit            sat_flag;
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // floor((acc + 2^(SHIFT-1)) / 2^SHIFT), then clamp or wrap to IW bits.
    function automatic logic [IW-1:0] quant(input logic [OW-1:0] a, output bit clamped);
        longint v, r;
        v = longint'($signed(a));
        r = (v + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
        clamped = 1'b0;
`ifdef FIR_OUT_SAT_EN
        if (r > 32767) begin
            clamped = 1'b1;
            r = 32767;
        end else if (r < -32768) begin
            clamped = 1'b1;
            r = -32768;
        end
`endif
        return IW'(r);
    endfunction

    task automatic model_step();
        bit pop, drop;
        if (rst) begin
            mq.delete();
            m_ce_q = 0; m_s1_v = 0; m_s1_sat = 0; m_ovf = 0; m_sat = 0;
            return;
        end
        pop  = (mq.size() != 0) && ready;
        drop = m_s1_v && (mq.size() == int'(DEPTH)) && !pop;
        if (pop) void'(mq.pop_front());
        if (m_s1_v && !drop) mq.push_back(m_s1_val);
        if (drop) m_ovf = 1; else if (clr) m_ovf = 0;
        if (m_s1_v && !drop && m_s1_sat) m_sat = 1; else if (clr) m_sat = 0;
        m_s1_v = m_ce_q;
        if (m_ce_q) m_s1_val = quant(acc, m_s1_sat);
        m_ce_q = ce;
    endtask

    task automatic compare_all();
        check("valid", 40'(valid), 40'(mq.size() != 0));
        check("level", 40'(level), 40'(mq.size()));
        if (mq.size() != 0) check("data", 40'(data), 40'(mq[0]));
        check("overflow", 40'(ovf), 40'(m_ovf));
`ifdef FIR_OUT_SAT_EN
        check("sat", 40'(sat), 40'(m_sat));
`endif
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    function automatic logic [OW-1:0] rand_acc();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return $signed(r[OW-1:0]) >>> $urandom_range(0, OW - 1);
    endfunction

    initial begin
        vecs[0] = '{40'h00_0000_4000, 16'h0001, 16'h0001, 1'b0};
        vecs[1] = '{40'h00_0000_3FFF, 16'h0000, 16'h0000, 1'b0};
        vecs[2] = '{40'hFF_FFFF_BFFF, 16'hFFFF, 16'hFFFF, 1'b0};
        vecs[3] = '{40'hFF_FFFF_C000, 16'h0000, 16'h0000, 1'b0};
        vecs[4] = '{40'hFF_FFFF_FFFF, 16'h0000, 16'h0000, 1'b0};
        vecs[5] = '{40'h00_8000_0000, 16'h0000, 16'h7FFF, 1'b1};
        vecs[6] = '{40'hFF_8000_0000, 16'h0000, 16'h8000, 1'b1};
        vecs[7] = '{40'h00_3FFF_BFFF, 16'h7FFF, 16'h7FFF, 1'b0};
        vecs[8] = '{40'h00_3FFF_C000, 16'h8000, 16'h7FFF, 1'b1};
        vecs[9] = '{40'hFF_C000_0000, 16'h8000, 16'h8000, 1'b0};

        rst = 1'b1; ce = 1'b0; ready = 1'b0; clr = 1'b0; acc = '0;
        tick();
        tick();
        check("rst_valid", 40'(valid), 40'(0));
        check("rst_level", 40'(level), 40'(0));
        check("rst_data", 40'(data), 40'(0));
        check("rst_ovf", 40'(ovf), 40'(0));
        rst = 1'b0;

        // Directed vectors: three-cycle latency and rounding/quantisation results.
        ready = 1'b1;
        foreach (vecs[i]) begin
            acc = vecs[i].acc;
            ce  = 1'b1;
            tick();
            ce = 1'b0;
            check("lat_n1", 40'(valid), 40'(0));
            tick();
            check("lat_n2", 40'(valid), 40'(0));
            tick();
            check("lat_n3", 40'(valid), 40'(1));
`ifdef FIR_OUT_SAT_EN
            check("vec_data", 40'(data), 40'(vecs[i].exp_sat));
            check("vec_sat", 40'(sat), 40'(vecs[i].sat_flag));
`else
            check("vec_data", 40'(data), 40'(vecs[i].exp_wrap));
`endif
            clr = 1'b1;
            tick();
            clr = 1'b0;
            tick();
        end

        // Six strobes into a stalled consumer: four kept, two dropped.
        ready = 1'b0;
        for (int k = 0; k < 7; k++) begin
            acc = 40'(k + 1) << SHIFT;
            ce  = (k < 6);
            tick();
        end
        ce = 1'b0;
        tick();
        tick();
        check("ovf_level", 40'(level), 40'(4));
        check("ovf_flag", 40'(ovf), 40'(1));
        ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            check("drain_valid", 40'(valid), 40'(1));
            check("drain_data", 40'(data), 40'(j + 2));
            tick();
        end
        check("drain_empty", 40'(valid), 40'(0));

        // Write into a full FIFO while the head is popped.
        clr = 1'b1; ready = 1'b0;
        tick();
        clr = 1'b0;
        acc = 40'h00_0000_8000;
        ce  = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        ce = 1'b0;
        tick();
        tick();
        check("full_level", 40'(level), 40'(4));
        ce = 1'b1;
        tick();
        ce = 1'b0;
        tick();
        ready = 1'b1;
        tick();
        check("fullpop_level", 40'(level), 40'(4));
        check("fullpop_ovf", 40'(ovf), 40'(0));
        for (int k = 0; k < 5; k++) tick();
        check("fullpop_empty", 40'(valid), 40'(0));

        // Asynchronous reset with three buffered samples and one in stage 1.
        ready = 1'b0;
        acc   = 40'h00_0001_0000;
        ce    = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        ce = 1'b0;
        tick();
        check("prerst_level", 40'(level), 40'(3));
        #2 rst = 1'b1;
        #1;
        check("async_valid", 40'(valid), 40'(0));
        check("async_level", 40'(level), 40'(0));
        check("async_data", 40'(data), 40'(0));
        tick();
        rst = 1'b0;
        acc = 40'(3) << SHIFT;
        ce  = 1'b1;
        tick();
        ce = 1'b0;
        check("postrst_n1", 40'(valid), 40'(0));
        tick();
        check("postrst_n2", 40'(valid), 40'(0));
        tick();
        check("postrst_n3", 40'(valid), 40'(1));
        check("postrst_data", 40'(data), 40'(3));

        // Random traffic with alternating light and heavy back-pressure.
        for (int c = 0; c < 1600; c++) begin
            ce    = $urandom_range(0, 1) == 1;
            ready = $urandom_range(0, 9) < (((c / 200) % 2 == 1) ? 3 : 8);
            clr   = $urandom_range(0, 19) == 0;
            acc   = rand_acc();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
